fetch_queue: RTL

Instruction prefetch queue between the fetch stage and decode. Each cycle fetch may push one {PC, instruction} pair, taking the PC from `imem_addr_F` and the word read from instruction memory at that address. Decode pops pairs in program order through a valid/ready handshake. A taken branch (`PCSrc_F`) flushes every queued entry, so decode never sees wrong-path instructions.

---
 rtl/fetch_queue.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a circular buffer of
// {PC, instruction} pairs with show-ahead head output and branch flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int N     = 64,
    parameter int IW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid_F,
    input  logic [N-1:0]             enq_pc_F,
    input  logic [IW-1:0]            enq_instr_F,
    output logic                     enq_ready_F,
    input  logic                     flush_F,
    output logic                     deq_valid_D,
    output logic [N-1:0]             deq_pc_D,
    output logic [IW-1:0]            deq_instr_D,
    input  logic                     deq_ready_D,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  pc_mem    [DEPTH];
    logic [IW-1:0] instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq_fire;
    logic          deq_fire;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; ready/valid here come only from registered count, so neither
    // side has a combinational path from the other side's inputs.
    assign enq_ready_F = (count < CW'(DEPTH));
    assign deq_valid_D = (count != '0);
    assign enq_fire    = enq_valid_F && enq_ready_F;
    assign deq_fire    = deq_valid_D && deq_ready_D;

    // Stale storage stays behind after a flush, so the head is masked when empty.
    assign deq_pc_D    = deq_valid_D ? pc_mem[rd_ptr]    : '0;
    assign deq_instr_D = deq_valid_D ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_F) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !flush_F) begin
            pc_mem[wr_ptr]    <= enq_pc_F;
            instr_mem[wr_ptr] <= enq_instr_F;
        end
    end

endmodule
